bpsk_carrier_mod: RTL and testbench
===================================

Name: bpsk_carrier_mod

Overview:
- Downstream consumer of the NCO sine output in the BPSK transmit path.
- Frames a serial bit stream as follows:
  - fixed alternating preamble;
  - optional differential encoding of the data bits;
  - maps each symbol to +/- the NCO carrier, held for SPS carrier samples per symbol.
- Output feeds the DAC interface.

Parameters:
- mpr, 10, carrier/output sample width (signed two's complement), matches NCO output width.
- sps, 16, carrier samples per symbol (>=2).
- spsw, 5, sample counter width; must satisfy 2**spsw > sps.
- pre_len, 8, preamble length in symbols (>=1); preamble is 1,0,1,0,...
- prew, 4, preamble counter width; must satisfy 2**prew > pre_len.
- diff_en, 1, 1 = differential encoding of data bits, 0 = direct mapping.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  clock enable; all state frozen when low.
- carr_valid  in  1  NCO out_valid; qualifies carr_sin.
- carr_sin  in  mpr  NCO fsin_o, signed.
- tx_start  in  1  frame start request, sampled in IDLE only.
- bit_valid  in  1  data bit offered.
- bit_data  in  1  data bit value.
- bit_last  in  1  marks final bit of frame, qualified by bit_valid.
- bit_ready  out  1  block accepts bit this cycle.
- mod_o  out  mpr  modulated sample, signed.
- mod_valid  out  1  mod_o valid.
- busy  out  1  state != IDLE.
- underrun  out  1  single-cycle pulse: data starved at a symbol boundary.

Behaviour:
- Reset: clk, reset as above; reset asynchronous, active-high. All outputs 0; state IDLE; counters 0; holding register empty; encoder state 0.
- Every register updates only when clken=1.
- tick = clken & carr_valid & (state != IDLE). boundary = tick & (samp_cnt == sps-1).
- samp_cnt advances by 1 on each tick and wraps to 0 on boundary.
- States:
  - IDLE:
    - tx_start=1 -> PRE; cur_sym=1, samp_cnt=0, pre_cnt=0.
    - tx_start while busy is ignored.
  - PRE: on boundary, pre_cnt+1.
    - If pre_cnt != pre_len-1: cur_sym toggles.
    - Else go to DATA and load first data symbol (load rule below).
  - DATA: on boundary:
    - If cur_last=1 -> IDLE.
    - Else load the next symbol.
- Load rule:
  - If holding register full: b = held bit; cur_last = held last; register empties the same cycle.
  - cur_sym = b when diff_en=0; cur_sym = enc ^ b when diff_en=1, and enc <= new cur_sym.
  - If holding register empty at a load: underrun pulses 1 cycle; state -> IDLE.
  - enc is cleared to 0 on every PRE entry.
- Holding register: one entry of {bit, last}.
  - bit_ready = clken & busy & ~full.
  - Accept when bit_valid & bit_ready.
  - Accept and drain in the same cycle: register ends full with the new bit. Permitted only if it was full at the start of that cycle; bit_ready is already low then, so no accept occurs.
  - Bits offered in IDLE are not accepted (bit_ready=0).
- Mapping on each tick, registered (1 clken-cycle latency):
  - cur_sym=1 -> mod_o = carr_sin.
  - cur_sym=0 -> mod_o = -carr_sin, saturated: input -2**(mpr-1) maps to 2**(mpr-1)-1 (for mpr=10: -512 -> +511).
  - mod_valid = registered tick.
- With clken=1 and no tick: mod_valid=0; mod_o holds its value.
- Returning to IDLE (after last symbol or underrun): the final tick's sample is still output with mod_valid=1 next cycle. mod_o is then cleared to 0 on the following clken cycle.
- carr_valid low mid-symbol: samp_cnt holds; the symbol stretches; no samples are lost.
- Reset asserted mid-frame: immediate return to reset values; a pending bit in the holding register is discarded.

Decomposition:
- Package bpsk_mod_pkg:
  - state encoding (IDLE=0, PRE=1, DATA=2);
  - localparams SMAX = 2**(mpr-1)-1 and SMIN = -2**(mpr-1).
- Sub-module bpsk_sym_map: combinational saturating conditional negate (cur_sym, carr_sin -> sample). Output register stays in the parent.
- FSM, counters, holding register and encoder stay in bpsk_carrier_mod (~200 lines).

Test Plan:
All scenarios use sps=4, pre_len=2, mpr=10, carr_valid=1 continuously, carr_sin ramp 1,2,3,..., unless stated.
1. Preamble: pulse tx_start; no bits offered -> mod_o = 1,2,3,4,-5,-6,-7,-8; then underrun pulse at the 8th tick; busy falls; mod_o = 0.
2. diff_en=1; bits 1,1,0 (last on 3rd), fed as soon as bit_ready -> data symbols 1,0,0. Data samples +9..+12, -13..-16, -17..-20; then IDLE, no underrun.
3. diff_en=0; same bits -> data symbols 1,1,0; signs +,+,- per 4-sample group.
4. Saturation: cur_sym=0, carr_sin=-512 -> mod_o=+511; carr_sin=+511 -> -511.
5. Stall: toggle carr_valid 1,0 during a symbol -> each symbol still spans exactly 4 valid samples. clken=0 for 3 cycles -> all outputs and counters frozen.
6. Reset mid-DATA with the holding register full -> all outputs 0 asynchronously. After release, tx_start starts a fresh preamble with enc=0; bit_ready=1 once busy.

Source files
------------

// File: rtl/bpsk_mod_pkg.sv
// Shared types and limits for the BPSK carrier modulator.
// SMAX/SMIN are the saturation limits at the default carrier width.
package bpsk_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int MPR  = 10;
  localparam int SMAX = 2**(MPR-1) - 1;
  localparam int SMIN = -(2**(MPR-1));

endpackage

// File: rtl/bpsk_sym_map.sv
// Maps one BPSK symbol onto the carrier: pass for 1, saturating negate for 0.
module bpsk_sym_map
  import bpsk_mod_pkg::*;
#(
  parameter int mpr = MPR
) (
  input  logic                  cur_sym,
  input  logic signed [mpr-1:0] carr_sin,
  output logic signed [mpr-1:0] sample
);

  localparam logic signed [mpr-1:0] SAT_MAX = {1'b0, {(mpr-1){1'b1}}};
  localparam logic signed [mpr-1:0] SAT_MIN = {1'b1, {(mpr-1){1'b0}}};

  // The most negative code has no positive twin, so it clips to full scale.
  function automatic logic signed [mpr-1:0] sat_neg(input logic signed [mpr-1:0] x);
    if (x == SAT_MIN) return SAT_MAX;
    return -x;
  endfunction

  always_comb begin
    sample = cur_sym ? carr_sin : sat_neg(carr_sin);
  end

endmodule

// File: rtl/bpsk_carrier_mod.sv
// BPSK transmit framer/modulator: alternating preamble, optional differential
// encoding, each symbol held for sps carrier samples, registered output.
module bpsk_carrier_mod
  import bpsk_mod_pkg::*;
#(
  parameter int mpr     = 10,
  parameter int sps     = 16,
  parameter int spsw    = 5,
  parameter int pre_len = 8,
  parameter int prew    = 4,
  parameter int diff_en = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  carr_valid,
  input  logic signed [mpr-1:0] carr_sin,
  input  logic                  tx_start,
  input  logic                  bit_valid,
  input  logic                  bit_data,
  input  logic                  bit_last,
  output logic                  bit_ready,
  output logic signed [mpr-1:0] mod_o,
  output logic                  mod_valid,
  output logic                  busy,
  output logic                  underrun
);

  localparam logic [spsw-1:0] SPS_LAST = spsw'(sps - 1);
  localparam logic [prew-1:0] PRE_LAST = prew'(pre_len - 1);

  state_t                state, state_nxt;
  logic [spsw-1:0]       samp_cnt;
  logic [prew-1:0]       pre_cnt;
  logic                  cur_sym, cur_last, enc;
  logic                  hold_full, hold_bit, hold_last;
  logic signed [mpr-1:0] mod_p1;
  logic                  vld_p1, und_p1;

  logic                  tick, boundary, last_pre, load, drain, starve, accept;
  logic                  new_sym;
  logic signed [mpr-1:0] sample_p0;

  always_comb begin
    busy      = (state != ST_IDLE);
    tick      = clken & carr_valid & busy;
    boundary  = tick & (samp_cnt == SPS_LAST);
    last_pre  = (pre_cnt == PRE_LAST);
    load      = boundary & (((state == ST_PRE) & last_pre) |
                            ((state == ST_DATA) & ~cur_last));
    drain     = load & hold_full;
    starve    = load & ~hold_full;
    bit_ready = clken & busy & ~hold_full;
    accept    = bit_valid & bit_ready;
    new_sym   = (diff_en != 0) ? (enc ^ hold_bit) : hold_bit;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (tx_start) state_nxt = ST_PRE;
      ST_PRE:  if (boundary && last_pre) state_nxt = starve ? ST_IDLE : ST_DATA;
      ST_DATA: if (boundary && (cur_last || !hold_full)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else if (clken) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_cnt  <= '0;
      pre_cnt   <= '0;
      cur_sym   <= 1'b0;
      cur_last  <= 1'b0;
      enc       <= 1'b0;
      hold_full <= 1'b0;
    end else if (clken) begin
      if ((state == ST_IDLE) && tx_start) begin
        samp_cnt <= '0;
        pre_cnt  <= '0;
        cur_sym  <= 1'b1;
        cur_last <= 1'b0;
        enc      <= 1'b0;
      end else if (tick) begin
        samp_cnt <= boundary ? '0 : samp_cnt + 1'b1;
      end
      if (boundary && (state == ST_PRE)) begin
        pre_cnt <= pre_cnt + 1'b1;
        if (!last_pre) cur_sym <= ~cur_sym;
      end
      if (drain) begin
        cur_sym  <= new_sym;
        cur_last <= hold_last;
        if (diff_en != 0) enc <= new_sym;
      end
      // A drain needs a full register while an accept needs an empty one.
      if (drain) hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clken && accept) begin
      hold_bit  <= bit_data;
      hold_last <= bit_last;
    end
  end

  bpsk_sym_map #(.mpr(mpr)) u_map (
    .cur_sym  (cur_sym),
    .carr_sin (carr_sin),
    .sample   (sample_p0)
  );

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_p1 <= '0;
      vld_p1 <= 1'b0;
      und_p1 <= 1'b0;
    end else if (clken) begin
      vld_p1 <= tick;
      und_p1 <= starve;
      if (tick) mod_p1 <= sample_p0;
      else if (state == ST_IDLE) mod_p1 <= '0;
    end
  end

  assign mod_o     = mod_p1;
  assign mod_valid = vld_p1;
  assign underrun  = und_p1;

endmodule

// File: tb/tb_bpsk_carrier_mod.sv
// Bench for bpsk_carrier_mod: a differential and a direct instance share all
// inputs; expected samples are queued per instance and popped on mod_valid.
module tb_bpsk_carrier_mod;

  typedef struct {
    int carr;
    int exp_mod;
  } vec_t;

  typedef struct {
    bit b;
    bit last;
  } bitrec_t;

  logic clk = 1'b0;
  logic reset, clken, carr_valid, tx_start, bit_valid, bit_data, bit_last;
  logic signed [9:0] carr_sin;

  logic bit_ready_d, mod_valid_d, busy_d, underrun_d;
  logic bit_ready_n, mod_valid_n, busy_n, underrun_n;
  logic signed [9:0] mod_o_d, mod_o_n;

  always #5 clk = ~clk;

  bpsk_carrier_mod #(.mpr(10), .sps(4), .spsw(3), .pre_len(2), .prew(2), .diff_en(1)) dut_d (
    .clk(clk), .reset(reset), .clken(clken), .carr_valid(carr_valid), .carr_sin(carr_sin),
    .tx_start(tx_start), .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last),
    .bit_ready(bit_ready_d), .mod_o(mod_o_d), .mod_valid(mod_valid_d), .busy(busy_d),
    .underrun(underrun_d)
  );

  bpsk_carrier_mod #(.mpr(10), .sps(4), .spsw(3), .pre_len(2), .prew(2), .diff_en(0)) dut_n (
    .clk(clk), .reset(reset), .clken(clken), .carr_valid(carr_valid), .carr_sin(carr_sin),
    .tx_start(tx_start), .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last),
    .bit_ready(bit_ready_n), .mod_o(mod_o_n), .mod_valid(mod_valid_n), .busy(busy_n),
    .underrun(underrun_n)
  );

  int n_checks = 0;
  int n_pass   = 0;

  vec_t    vecs [16];
  int      samp_tab [64];
  bitrec_t bitq [$];
  int      q_d [$];
  int      q_n [$];
  int      bit_idx, k, cyc, und_d, und_n;
  int      cv_mode, freeze_at, tx_pulse_cyc;
  bit      tx_req, acc, cons, edge_clken;
  int      snap_mod, snap_vld, snap_busy;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int map_exp(input bit sym, input int c);
    if (sym) return c;
    if (c == -512) return 511;
    return -c;
  endfunction

  task automatic push_sym(input int s, input bit sd, input bit sn);
    for (int j = 0; j < 4; j++) begin
      q_d.push_back(map_exp(sd, samp_tab[4*s+j]));
      q_n.push_back(map_exp(sn, samp_tab[4*s+j]));
    end
  endtask

  // Reference framing: preamble 1,0 then data symbols up to the last-marked bit.
  task automatic push_model();
    int s;
    bit e;
    s = 0;
    e = 1'b0;
    for (int p = 0; p < 2; p++) begin
      push_sym(s, (p % 2) == 0, (p % 2) == 0);
      s++;
    end
    for (int i = 0; i < bitq.size(); i++) begin
      e = e ^ bitq[i].b;
      push_sym(s, e, bitq[i].b);
      s++;
      if (bitq[i].last) break;
    end
  endtask

  task automatic add_bit(input bit b, input bit l);
    bitrec_t r;
    r.b = b;
    r.last = l;
    bitq.push_back(r);
  endtask

  task automatic new_frame();
    bitq.delete();
    q_d.delete();
    q_n.delete();
    bit_idx = 0;
    k = 0;
    acc = 1'b0;
    cons = 1'b0;
    for (int i = 0; i < 64; i++) samp_tab[i] = i + 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_clken = clken;
    if (acc) bit_idx++;
    if (cons) k++;
    #1;
    cyc++;
    tx_start   = tx_req || (cyc == tx_pulse_cyc);
    tx_req     = 1'b0;
    clken      = !(freeze_at >= 0 && cyc >= freeze_at && cyc < freeze_at + 3);
    carr_valid = (cv_mode == 0) ? 1'b1 : cyc[0];
    carr_sin   = 10'(samp_tab[k]);
    bit_valid  = (bit_idx < bitq.size());
    bit_data   = bit_valid ? bitq[bit_idx].b : 1'b0;
    bit_last   = bit_valid ? bitq[bit_idx].last : 1'b0;
    @(negedge clk);
    if (edge_clken) begin
      if (mod_valid_d) begin
        if (q_d.size() == 0) begin
          n_checks++;
          $display("FAIL mod_d: got sample %0d, expected no sample", mod_o_d);
        end else chk("mod_d", mod_o_d, q_d.pop_front());
      end
      if (mod_valid_n) begin
        if (q_n.size() == 0) begin
          n_checks++;
          $display("FAIL mod_n: got sample %0d, expected no sample", mod_o_n);
        end else chk("mod_n", mod_o_n, q_n.pop_front());
      end
      if (underrun_d) und_d++;
      if (underrun_n) und_n++;
      snap_mod  = mod_o_d;
      snap_vld  = mod_valid_d;
      snap_busy = busy_d;
    end else begin
      chk("frz_mod", mod_o_d, snap_mod);
      chk("frz_vld", mod_valid_d, snap_vld);
      chk("frz_busy", busy_d, snap_busy);
      chk("frz_rdy", bit_ready_d, 0);
    end
    acc  = bit_valid & bit_ready_d;
    cons = clken & carr_valid & busy_d;
  endtask

  task automatic run_frame(input string tag, input int exp_und);
    int guard;
    bit seen;
    guard = 0;
    seen = 1'b0;
    chk({tag, "_idle_rdy"}, bit_ready_d | bit_ready_n, 0);
    und_d = 0;
    und_n = 0;
    cyc = 0;
    tx_req = 1'b1;
    do begin
      cycle();
      guard++;
      if (busy_d && !seen) begin
        seen = 1'b1;
        chk({tag, "_rdy_busy"}, bit_ready_d, 1);
      end
    end while (!(seen && !busy_d && q_d.size() == 0 && q_n.size() == 0) && guard < 200);
    chk({tag, "_done_in_time"}, int'(guard < 200), 1);
    chk({tag, "_q_left"}, q_d.size() + q_n.size(), 0);
    chk({tag, "_und_d"}, und_d, exp_und);
    chk({tag, "_und_n"}, und_n, exp_und);
    cycle();
    chk({tag, "_mod_clr_d"}, mod_o_d, 0);
    chk({tag, "_mod_clr_n"}, mod_o_n, 0);
    chk({tag, "_vld_low"}, mod_valid_d | mod_valid_n, 0);
    chk({tag, "_idle"}, busy_d | busy_n | underrun_d | underrun_n, 0);
  endtask

  task automatic run_table(input string tag, input int base);
    new_frame();
    for (int i = 0; i < 8; i++) begin
      samp_tab[i] = vecs[base+i].carr;
      q_d.push_back(vecs[base+i].exp_mod);
      q_n.push_back(vecs[base+i].exp_mod);
    end
    run_frame(tag, 1);
  endtask

  initial begin
    vecs = '{'{1, 1}, '{2, 2}, '{3, 3}, '{4, 4},
             '{5, -5}, '{6, -6}, '{7, -7}, '{8, -8},
             '{-512, -512}, '{511, 511}, '{-1, -1}, '{0, 0},
             '{-512, 511}, '{511, -511}, '{-1, 1}, '{5, -5}};
    reset = 1'b1;
    clken = 1'b1;
    carr_valid = 1'b1;
    carr_sin = '0;
    tx_start = 1'b0;
    bit_valid = 1'b0;
    bit_data = 1'b0;
    bit_last = 1'b0;
    tx_req = 1'b0;
    cv_mode = 0;
    freeze_at = -1;
    tx_pulse_cyc = -1;
    edge_clken = 1'b1;
    new_frame();
    repeat (3) @(negedge clk);
    chk("rst_mod", mod_o_d, 0);
    chk("rst_ctl", mod_valid_d | busy_d | underrun_d | bit_ready_d, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy_d | mod_valid_d | bit_ready_d, 0);

    // Preamble-only ramp, then saturation vectors through the preamble symbols.
    run_table("pre_ramp", 0);
    run_table("sat", 8);

    // Bits 1,1,0 with a stray tx_start mid-frame.
    new_frame();
    add_bit(1, 0); add_bit(1, 0); add_bit(0, 1);
    push_model();
    tx_pulse_cyc = 6;
    run_frame("bits110", 0);
    tx_pulse_cyc = -1;

    // Reset mid-DATA while the holding register holds the next bit.
    new_frame();
    add_bit(1, 0); add_bit(1, 0); add_bit(0, 1);
    push_model();
    cyc = 0;
    tx_req = 1'b1;
    for (int g = 0; g < 100 && !(k >= 10 && bit_idx >= 2 && !acc); g++) cycle();
    chk("pre_rst_busy", busy_d, 1);
    chk("pre_rst_full", bit_ready_d, 0);
    chk("pre_rst_vld", mod_valid_d, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mod", mod_o_d | mod_o_n, 0);
    chk("async_rst_ctl", mod_valid_d | busy_d | underrun_d | bit_ready_d, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh frame after reset: leaves the encoder at 1 for the next frame.
    new_frame();
    add_bit(1, 0); add_bit(0, 1);
    push_model();
    run_frame("after_rst", 0);

    // Stalled carrier plus a clken freeze; encoder must restart from 0.
    new_frame();
    add_bit(1, 0); add_bit(1, 0); add_bit(0, 1);
    push_model();
    cv_mode = 1;
    freeze_at = 9;
    run_frame("stall", 0);
    cv_mode = 0;
    freeze_at = -1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
